// File: rtl/menu_controller.sv
// menu_controller: button-driven cursor, duration editor and run-state owner
// for the traffic-light demo; every output comes straight from a flop.
module menu_controller #(
  parameter int unsigned GREEN_DEFAULT  = 10,
  parameter int unsigned YELLOW_DEFAULT = 3,
  parameter int unsigned RED_DEFAULT    = 2,
  parameter int unsigned DUR_MIN        = 1,
  parameter int unsigned DUR_MAX        = 99,
  parameter int unsigned REPEAT_DELAY   = 25_000_000,
  parameter int unsigned REPEAT_RATE    = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  output logic [3:0] menu_sel,
  output logic       edit_active,
  output logic [7:0] green_duration,
  output logic [7:0] yellow_duration,
  output logic [7:0] red_holding,
  output logic [1:0] run_state,
  output logic       cfg_update,
  output logic       stop_pulse
);
  localparam int unsigned CMAX =
    (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [7:0] DMIN = 8'(DUR_MIN);
  localparam logic [7:0] DMAX = 8'(DUR_MAX);
  localparam logic [1:0] RS_STOP  = 2'd0;
  localparam logic [1:0] RS_RUN   = 2'd1;
  localparam logic [1:0] RS_PAUSE = 2'd2;

  typedef enum logic {S_NAV, S_EDIT} state_t;

  state_t        r_state, w_state_nx;
  logic [3:0]    r_menu, w_menu_nx;
  logic [7:0]    r_green, r_yellow, r_red;
  logic [7:0]    w_green_nx, w_yellow_nx, w_red_nx;
  logic [1:0]    r_run, w_run_nx;
  logic          r_cfg, w_cfg_nx;
  logic          r_stop, w_stop_nx;
  logic          r_up_q, r_dn_q, r_sel_q;
  logic          r_arm, w_arm_nx;
  logic          r_dir, w_dir_nx;
  logic          r_rep, w_rep_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;

  logic       w_up_only, w_dn_only;
  logic       w_up_pr, w_dn_pr, w_sel_pr;
  logic       w_is_dur, w_held, w_tick;
  logic       w_inc, w_dec;
  logic [7:0] w_cur, w_new;
  logic [3:0] w_menu_prev, w_menu_next;

  assign w_up_only = btn_up & ~btn_down;
  assign w_dn_only = btn_down & ~btn_up;
  assign w_up_pr   = w_up_only & ~r_up_q;
  assign w_dn_pr   = w_dn_only & ~r_dn_q;
  assign w_sel_pr  = btn_sel & ~r_sel_q;
  assign w_is_dur  = (r_menu == 4'd1) | (r_menu == 4'd2) | (r_menu == 4'd3);
  assign w_held    = r_arm & (r_dir ? w_dn_only : w_up_only);
  assign w_tick    = r_rep ? (r_cnt == CW'(REPEAT_RATE))
                           : (r_cnt == CW'(REPEAT_DELAY));

  // Cursor ring 1,2,3,6,7,8
  always_comb begin
    w_menu_next = 4'd1;
    w_menu_prev = 4'd8;
    unique case (r_menu)
      4'd1: begin w_menu_next = 4'd2; w_menu_prev = 4'd8; end
      4'd2: begin w_menu_next = 4'd3; w_menu_prev = 4'd1; end
      4'd3: begin w_menu_next = 4'd6; w_menu_prev = 4'd2; end
      4'd6: begin w_menu_next = 4'd7; w_menu_prev = 4'd3; end
      4'd7: begin w_menu_next = 4'd8; w_menu_prev = 4'd6; end
      4'd8: begin w_menu_next = 4'd1; w_menu_prev = 4'd7; end
      default: begin w_menu_next = 4'd1; w_menu_prev = 4'd1; end
    endcase
  end

  always_comb begin
    w_cur = r_green;
    if (r_menu == 4'd2) w_cur = r_yellow;
    else if (r_menu == 4'd3) w_cur = r_red;
  end

  // Repeat only follows a button armed by a real press inside EDIT
  always_comb begin
    w_inc    = 1'b0;
    w_dec    = 1'b0;
    w_arm_nx = 1'b0;
    w_dir_nx = r_dir;
    w_rep_nx = 1'b0;
    w_cnt_nx = '0;
    if (r_state == S_EDIT && !w_sel_pr) begin
      if (w_up_pr) begin
        w_inc    = 1'b1;
        w_arm_nx = 1'b1;
        w_dir_nx = 1'b0;
        w_cnt_nx = CW'(1);
      end else if (w_dn_pr) begin
        w_dec    = 1'b1;
        w_arm_nx = 1'b1;
        w_dir_nx = 1'b1;
        w_cnt_nx = CW'(1);
      end else if (w_held) begin
        w_arm_nx = 1'b1;
        w_rep_nx = r_rep | w_tick;
        w_cnt_nx = w_tick ? CW'(1) : r_cnt + CW'(1);
        w_inc    = w_tick & ~r_dir;
        w_dec    = w_tick & r_dir;
      end
    end
  end

  always_comb begin
    w_new = w_cur;
    if (w_inc) w_new = (w_cur >= DMAX) ? DMAX : w_cur + 8'd1;
    else if (w_dec) w_new = (w_cur <= DMIN) ? DMIN : w_cur - 8'd1;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_NAV:
        if (w_sel_pr && w_is_dur && r_run != RS_RUN) w_state_nx = S_EDIT;
      S_EDIT:
        if (w_sel_pr) w_state_nx = S_NAV;
    endcase
  end

  always_comb begin
    w_menu_nx   = r_menu;
    w_run_nx    = r_run;
    w_green_nx  = r_green;
    w_yellow_nx = r_yellow;
    w_red_nx    = r_red;
    w_cfg_nx    = 1'b0;
    w_stop_nx   = 1'b0;
    unique case (r_state)
      S_NAV: begin
        if (w_sel_pr) begin
          unique case (r_menu)
            4'd6: w_run_nx = RS_RUN;
            4'd7: if (r_run == RS_RUN) w_run_nx = RS_PAUSE;
            4'd8: begin
              w_run_nx  = RS_STOP;
              w_stop_nx = 1'b1;
            end
            default: ;
          endcase
        end else if (w_up_pr) begin
          w_menu_nx = w_menu_prev;
        end else if (w_dn_pr) begin
          w_menu_nx = w_menu_next;
        end
      end
      S_EDIT: begin
        w_cfg_nx = w_sel_pr;
        if (r_menu == 4'd2) w_yellow_nx = w_new;
        else if (r_menu == 4'd3) w_red_nx = w_new;
        else w_green_nx = w_new;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_NAV;
      r_menu   <= 4'd1;
      r_green  <= 8'(GREEN_DEFAULT);
      r_yellow <= 8'(YELLOW_DEFAULT);
      r_red    <= 8'(RED_DEFAULT);
      r_run    <= RS_STOP;
      r_cfg    <= 1'b0;
      r_stop   <= 1'b0;
      r_up_q   <= 1'b0;
      r_dn_q   <= 1'b0;
      r_sel_q  <= 1'b0;
      r_arm    <= 1'b0;
      r_dir    <= 1'b0;
      r_rep    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_menu   <= w_menu_nx;
      r_green  <= w_green_nx;
      r_yellow <= w_yellow_nx;
      r_red    <= w_red_nx;
      r_run    <= w_run_nx;
      r_cfg    <= w_cfg_nx;
      r_stop   <= w_stop_nx;
      r_up_q   <= btn_up;
      r_dn_q   <= btn_down;
      r_sel_q  <= btn_sel;
      r_arm    <= w_arm_nx;
      r_dir    <= w_dir_nx;
      r_rep    <= w_rep_nx;
      r_cnt    <= w_cnt_nx;
    end
  end

  assign menu_sel        = r_menu;
  assign edit_active     = (r_state == S_EDIT);
  assign green_duration  = r_green;
  assign yellow_duration = r_yellow;
  assign red_holding     = r_red;
  assign run_state       = r_run;
  assign cfg_update      = r_cfg;
  assign stop_pulse      = r_stop;
endmodule

// File: tb/tb_menu_controller.sv
// tb_menu_controller: directed vector table plus hand-built sequences for
// saturation, held-at-entry, auto-repeat timing and reset mid-edit.
module tb_menu_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_down, btn_sel;
  logic [3:0] menu_sel;
  logic       edit_active;
  logic [7:0] green_duration, yellow_duration, red_holding;
  logic [1:0] run_state;
  logic       cfg_update, stop_pulse;

  menu_controller #(
    .REPEAT_DELAY(4),
    .REPEAT_RATE (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_up         (btn_up),
    .btn_down       (btn_down),
    .btn_sel        (btn_sel),
    .menu_sel       (menu_sel),
    .edit_active    (edit_active),
    .green_duration (green_duration),
    .yellow_duration(yellow_duration),
    .red_holding    (red_holding),
    .run_state      (run_state),
    .cfg_update     (cfg_update),
    .stop_pulse     (stop_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       u, d, s;
    logic [3:0] m;
    logic       e;
    logic [7:0] g, y, r;
    logic [1:0] rs;
    logic       c, p;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // press vector followed by a release vector (pulses drop on release)
  task automatic pr(input logic u, d, s, input logic [3:0] m,
                    input logic e, input logic [7:0] g, y, r,
                    input logic [1:0] rs, input logic c, p);
    vec_t v;
    v.u = u; v.d = d; v.s = s; v.m = m; v.e = e;
    v.g = g; v.y = y; v.r = r; v.rs = rs; v.c = c; v.p = p;
    tbl.push_back(v);
    v.u = 1'b0; v.d = 1'b0; v.s = 1'b0; v.c = 1'b0; v.p = 1'b0;
    tbl.push_back(v);
  endtask

  task automatic cyc(input logic u, d, s);
    @(negedge clk);
    btn_up = u; btn_down = d; btn_sel = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] m,
                     input logic e, input logic [7:0] g, y, r,
                     input logic [1:0] rs, input logic c, p);
    n_vec++;
    if ({menu_sel, edit_active, green_duration, yellow_duration,
         red_holding, run_state, cfg_update, stop_pulse}
        !== {m, e, g, y, r, rs, c, p}) begin
      n_bad++;
      $display("FAIL %s: got m=%0d e=%0d g=%0d y=%0d r=%0d run=%0d cfg=%0d stop=%0d want m=%0d e=%0d g=%0d y=%0d r=%0d run=%0d cfg=%0d stop=%0d",
               nm, menu_sel, edit_active, green_duration, yellow_duration,
               red_holding, run_state, cfg_update, stop_pulse,
               m, e, g, y, r, rs, c, p);
    end
  endtask

  function automatic int steps(input int k);
    return 1 + ((k >= 4) ? ((k - 4) / 2 + 1) : 0);
  endfunction

  initial begin
    reset = 1'b1;
    btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;

    // cursor ring
    pr(0,1,0, 2,0,10,3,2,0,0,0);
    pr(0,1,0, 3,0,10,3,2,0,0,0);
    pr(0,1,0, 6,0,10,3,2,0,0,0);
    pr(0,1,0, 7,0,10,3,2,0,0,0);
    pr(0,1,0, 8,0,10,3,2,0,0,0);
    pr(0,1,0, 1,0,10,3,2,0,0,0);
    pr(1,0,0, 8,0,10,3,2,0,0,0);
    pr(0,1,0, 1,0,10,3,2,0,0,0);
    // edit green +3
    pr(0,0,1, 1,1,10,3,2,0,0,0);
    pr(1,0,0, 1,1,11,3,2,0,0,0);
    pr(1,0,0, 1,1,12,3,2,0,0,0);
    pr(1,0,0, 1,1,13,3,2,0,0,0);
    pr(0,0,1, 1,0,13,3,2,0,1,0);
    // edit yellow down x5, saturates at 1
    pr(0,1,0, 2,0,13,3,2,0,0,0);
    pr(0,0,1, 2,1,13,3,2,0,0,0);
    pr(0,1,0, 2,1,13,2,2,0,0,0);
    pr(0,1,0, 2,1,13,1,2,0,0,0);
    pr(0,1,0, 2,1,13,1,2,0,0,0);
    pr(0,1,0, 2,1,13,1,2,0,0,0);
    pr(0,1,0, 2,1,13,1,2,0,0,0);
    pr(0,0,1, 2,0,13,1,2,0,1,0);
    // run state commands
    pr(0,1,0, 3,0,13,1,2,0,0,0);
    pr(0,1,0, 6,0,13,1,2,0,0,0);
    pr(0,0,1, 6,0,13,1,2,1,0,0);
    pr(1,0,0, 3,0,13,1,2,1,0,0);
    pr(1,0,0, 2,0,13,1,2,1,0,0);
    pr(1,0,0, 1,0,13,1,2,1,0,0);
    pr(0,0,1, 1,0,13,1,2,1,0,0);
    pr(1,0,0, 8,0,13,1,2,1,0,0);
    pr(1,0,0, 7,0,13,1,2,1,0,0);
    pr(0,0,1, 7,0,13,1,2,2,0,0);
    pr(0,0,1, 7,0,13,1,2,2,0,0);
    pr(1,1,0, 7,0,13,1,2,2,0,0);
    pr(0,1,0, 8,0,13,1,2,2,0,0);
    pr(0,0,1, 8,0,13,1,2,0,0,1);
    pr(1,0,1, 8,0,13,1,2,0,0,1);
    pr(0,1,0, 1,0,13,1,2,0,0,0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset", 1,0,10,3,2,0,0,0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].u, tbl[i].d, tbl[i].s);
      chk($sformatf("vec%0d", i), tbl[i].m, tbl[i].e, tbl[i].g,
          tbl[i].y, tbl[i].r, tbl[i].rs, tbl[i].c, tbl[i].p);
    end

    // green held up to saturation, then one more press
    cyc(0,0,1); chk("g_enter", 1,1,13,1,2,0,0,0);
    cyc(0,0,0);
    repeat (200) cyc(1,0,0);
    chk("g_sat_hold", 1,1,99,1,2,0,0,0);
    cyc(0,0,0);
    cyc(1,0,0); chk("g_sat_press", 1,1,99,1,2,0,0,0);
    cyc(0,0,0);
    cyc(0,0,1); chk("g_commit", 1,0,99,1,2,0,1,0);
    cyc(0,0,0); chk("g_cfg_drop", 1,0,99,1,2,0,0,0);

    // red hold edit
    cyc(0,1,0); cyc(0,0,0); cyc(0,1,0); cyc(0,0,0);
    chk("r_nav", 3,0,99,1,2,0,0,0);
    cyc(0,0,1); chk("r_enter", 3,1,99,1,2,0,0,0);
    cyc(0,0,0);
    cyc(1,0,0); chk("r_up", 3,1,99,1,3,0,0,0);
    cyc(0,0,0);
    cyc(0,0,1); chk("r_commit", 3,0,99,1,3,0,1,0);
    cyc(0,0,0);

    // up held through EDIT entry gives no step
    cyc(1,0,1); chk("held_enter", 3,1,99,1,3,0,0,0);
    repeat (6) cyc(1,0,0);
    chk("held_nostep", 3,1,99,1,3,0,0,0);
    cyc(0,0,0);
    cyc(1,0,0); chk("repress", 3,1,99,1,4,0,0,0);
    cyc(0,0,0);

    // auto-repeat: steps at hold cycles 0,4,6,8
    for (int k = 0; k < 10; k++) begin
      cyc(1,0,0);
      chk($sformatf("rep_k%0d", k), 3,1,99,1,8'(4 + steps(k)),0,0,0);
    end
    cyc(0,0,0);

    // reset at hold cycle 5 discards the edit
    for (int k = 0; k < 5; k++) cyc(1,0,0);
    chk("pre_reset", 3,1,99,1,10,0,0,0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_reset", 1,0,10,3,2,0,0,0);
    btn_up = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_held", 1,0,10,3,2,0,0,0);
    @(negedge clk);
    reset = 1'b0;
    cyc(0,0,0); chk("post_reset", 1,0,10,3,2,0,0,0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
